// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decodes MIPS opcode/funct into an ALU op, selects and extends
// the operands, and holds them in a single valid/ready output register with flush.
module alu_op_issue #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic [15:0]        imm,
  input  logic [REGADDR-1:0] rt_addr,
  input  logic [REGADDR-1:0] rd_addr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [4:0]         alu_op,
  output logic [REGADDR-1:0] dst_addr,
  output logic               reg_write,
  output logic               illegal
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_NOR = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;

  logic [WIDTH-1:0]   w_sext;
  logic [WIDTH-1:0]   w_zext;
  logic [WIDTH-1:0]   w_b;
  logic [4:0]         w_op;
  logic [REGADDR-1:0] w_dst;
  logic               w_wr;
  logic               w_ill;
  logic               w_accept;

  logic               r_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [4:0]         r_op;
  logic [REGADDR-1:0] r_dst;
  logic               r_wr;
  logic               r_ill;

  assign w_sext = {{(WIDTH-16){imm[15]}}, imm};
  assign w_zext = {{(WIDTH-16){1'b0}}, imm};

  // Defaults describe the illegal/no-writeback case, so dst stays 0 unless a write is decoded.
  always_comb begin
    w_op  = OP_ADD;
    w_b   = rt_val;
    w_dst = '0;
    w_wr  = 1'b0;
    w_ill = 1'b0;
    case (opcode)
      6'b000000: begin
        w_wr  = 1'b1;
        w_dst = rd_addr;
        case (funct)
          6'b100000, 6'b100001: w_op = OP_ADD;
          6'b100010, 6'b100011: w_op = OP_SUB;
          6'b100100:            w_op = OP_AND;
          6'b100101:            w_op = OP_OR;
          6'b100111:            w_op = OP_NOR;
          default: begin
            w_op  = OP_ADD;
            w_wr  = 1'b0;
            w_dst = '0;
            w_ill = 1'b1;
          end
        endcase
      end
      6'b001000: begin w_op = OP_ADD; w_b = w_sext; w_dst = rt_addr; w_wr = 1'b1; end
      6'b001100: begin w_op = OP_AND; w_b = w_zext; w_dst = rt_addr; w_wr = 1'b1; end
      6'b001101: begin w_op = OP_OR;  w_b = w_zext; w_dst = rt_addr; w_wr = 1'b1; end
      6'b100011: begin w_op = OP_ADD; w_b = w_sext; w_dst = rt_addr; w_wr = 1'b1; end
      6'b101011: begin w_op = OP_ADD; w_b = w_sext; end
      6'b000100: begin w_op = OP_SUB; w_b = rt_val; end
      default:   w_ill = 1'b1;
    endcase
  end

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Output register; flush beats accept and clears only valid and the trap flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_dst   <= '0;
      r_wr    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_a     <= rs_val;
      r_b     <= w_b;
      r_op    <= w_op;
      r_dst   <= w_dst;
      r_wr    <= w_wr;
      r_ill   <= w_ill;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign dst_addr  = r_dst;
  assign reg_write = r_wr;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode cases, stall, flush and async reset,
// with hand-computed expectations checked by immediate assertions.
module tb_alu_op_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [15:0] imm;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [4:0]  dst_addr;
  logic        reg_write;
  logic        illegal;

  int errs = 0;
  int checks = 0;

  alu_op_issue #(.WIDTH(32), .REGADDR(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
    .imm(imm), .rt_addr(rt_addr), .rd_addr(rd_addr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .dst_addr(dst_addr), .reg_write(reg_write), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im,
                       input logic [4:0] rta, input logic [4:0] rda);
    in_valid = 1'b1;
    opcode = opc; funct = fn; rs_val = rs; rt_val = rt; imm = im;
    rt_addr = rta; rd_addr = rda;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
    rt_addr = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // load a sub and hold it, then reset between edges
    out_ready = 1'b0;
    drive(6'b000000, 6'b100010, 32'h7, 32'h2, 16'h0, 5'd0, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_op", {27'd0, alu_op}, 32'd1);
    chk("sub_a", alu_a, 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_a", alu_a, 32'd0);
    chk("arst_b", alu_b, 32'd0);
    chk("arst_op", {27'd0, alu_op}, 32'd0);
    chk("arst_dst", {27'd0, dst_addr}, 32'd0);
    chk("arst_rw", {31'd0, reg_write}, 32'd0);
    chk("arst_ill", {31'd0, illegal}, 32'd0);
    chk("arst_inrdy", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // R-type add
    drive(6'b000000, 6'b100000, 32'h5, 32'h3, 16'h0, 5'd1, 5'd9);
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_a", alu_a, 32'h5);
    chk("add_b", alu_b, 32'h3);
    chk("add_op", {27'd0, alu_op}, 32'd0);
    chk("add_dst", {27'd0, dst_addr}, 32'd9);
    chk("add_rw", {31'd0, reg_write}, 32'd1);

    // R-type nor, back to back
    drive(6'b000000, 6'b100111, 32'hF0, 32'h0F, 16'h0, 5'd1, 5'd3);
    tick();
    chk("nor_op", {27'd0, alu_op}, 32'd4);
    chk("nor_dst", {27'd0, dst_addr}, 32'd3);
    chk("nor_valid", {31'd0, out_valid}, 32'd1);

    // addi with negative immediate
    drive(6'b001000, 6'b000000, 32'h10, 32'h99, 16'hFFFE, 5'd6, 5'd20);
    tick();
    chk("addi_b", alu_b, 32'hFFFFFFFE);
    chk("addi_op", {27'd0, alu_op}, 32'd0);
    chk("addi_dst", {27'd0, dst_addr}, 32'd6);
    chk("addi_a", alu_a, 32'h10);

    // ori zero-extends
    drive(6'b001101, 6'b000000, 32'h1, 32'h99, 16'h8001, 5'd7, 5'd12);
    tick();
    chk("ori_b", alu_b, 32'h00008001);
    chk("ori_op", {27'd0, alu_op}, 32'd6);
    chk("ori_dst", {27'd0, dst_addr}, 32'd7);

    // stall three cycles with an andi waiting
    out_ready = 1'b0;
    drive(6'b001100, 6'b000000, 32'h1, 32'h99, 16'h00FF, 5'd8, 5'd13);
    #1;
    chk("stall_inrdy0", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_inrdy", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_op", {27'd0, alu_op}, 32'd6);
      chk("stall_b", alu_b, 32'h00008001);
      chk("stall_dst", {27'd0, dst_addr}, 32'd7);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_inrdy", {31'd0, in_ready}, 32'd1);
    tick();
    chk("andi_valid", {31'd0, out_valid}, 32'd1);
    chk("andi_op", {27'd0, alu_op}, 32'd5);
    chk("andi_b", alu_b, 32'h000000FF);
    chk("andi_dst", {27'd0, dst_addr}, 32'd8);

    // lw follows immediately
    drive(6'b100011, 6'b000000, 32'h40, 32'h99, 16'h0004, 5'd10, 5'd14);
    tick();
    chk("lw_op", {27'd0, alu_op}, 32'd0);
    chk("lw_b", alu_b, 32'h4);
    chk("lw_dst", {27'd0, dst_addr}, 32'd10);
    chk("lw_rw", {31'd0, reg_write}, 32'd1);

    // drain: valid drops, data holds
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_b", alu_b, 32'h4);

    // flush discards the incoming addi
    drive(6'b001000, 6'b000000, 32'h55, 32'h99, 16'h1234, 5'd11, 5'd15);
    flush = 1'b1;
    #1;
    chk("flush_inrdy", {31'd0, in_ready}, 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_b", alu_b, 32'h4);
    chk("flush_dst", {27'd0, dst_addr}, 32'd10);
    tick();
    chk("flush_valid2", {31'd0, out_valid}, 32'd0);

    // j is illegal but still flows
    drive(6'b000010, 6'b000000, 32'hAA, 32'hBB, 16'h0, 5'd6, 5'd5);
    tick();
    chk("j_valid", {31'd0, out_valid}, 32'd1);
    chk("j_ill", {31'd0, illegal}, 32'd1);
    chk("j_op", {27'd0, alu_op}, 32'd0);
    chk("j_rw", {31'd0, reg_write}, 32'd0);
    chk("j_dst", {27'd0, dst_addr}, 32'd0);
    chk("j_a", alu_a, 32'hAA);
    chk("j_b", alu_b, 32'hBB);

    // flush clears the held illegal flag
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flushill_ill", {31'd0, illegal}, 32'd0);
    chk("flushill_valid", {31'd0, out_valid}, 32'd0);

    // sw: no writeback, sign-extended offset
    drive(6'b101011, 6'b000000, 32'h100, 32'h77, 16'h8000, 5'd3, 5'd2);
    tick();
    chk("sw_rw", {31'd0, reg_write}, 32'd0);
    chk("sw_op", {27'd0, alu_op}, 32'd0);
    chk("sw_ill", {31'd0, illegal}, 32'd0);
    chk("sw_dst", {27'd0, dst_addr}, 32'd0);
    chk("sw_b", alu_b, 32'hFFFF8000);

    // beq: subtract, no writeback
    drive(6'b000100, 6'b000000, 32'h9, 32'h9, 16'h0010, 5'd2, 5'd1);
    tick();
    chk("beq_op", {27'd0, alu_op}, 32'd1);
    chk("beq_b", alu_b, 32'h9);
    chk("beq_rw", {31'd0, reg_write}, 32'd0);
    chk("beq_dst", {27'd0, dst_addr}, 32'd0);

    // R-type with unsupported funct
    drive(6'b000000, 6'b000000, 32'h3, 32'h4, 16'h0, 5'd2, 5'd17);
    tick();
    chk("rill_ill", {31'd0, illegal}, 32'd1);
    chk("rill_op", {27'd0, alu_op}, 32'd0);
    chk("rill_rw", {31'd0, reg_write}, 32'd0);
    chk("rill_dst", {27'd0, dst_addr}, 32'd0);

    // subu alias
    drive(6'b000000, 6'b100011, 32'h8, 32'h1, 16'h0, 5'd2, 5'd18);
    tick();
    chk("subu_op", {27'd0, alu_op}, 32'd1);
    chk("subu_ill", {31'd0, illegal}, 32'd0);
    chk("subu_dst", {27'd0, dst_addr}, 32'd18);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
